// File: rtl/regfile_multiport_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_multiport_if
// Purpose  : ID-stage register file bus. Carries the WB-stage write, the
//            packed operand read addresses and the registered read data,
//            plus the busy flag the pipeline stalls on.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_multiport_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) ();

  logic                     WB;
  logic [ADDR_W-1:0]        writeReg;
  logic [DATA_W-1:0]        writeData;
  logic [NUM_RD*ADDR_W-1:0] readReg;
  logic [NUM_RD*DATA_W-1:0] RegData;
  logic                     busy;

  // Pipeline side: issues writes and read addresses, consumes data/busy
  modport master (
    output WB, writeReg, writeData, readReg,
    input  RegData, busy
  );

  // Register file side
  modport slave (
    input  WB, writeReg, writeData, readReg,
    output RegData, busy
  );

endinterface
`default_nettype wire

// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : regfile_multiport
// Purpose  : Parametrised multi-read-port register file with register 0
//            hardwired to zero, a post-reset clear sequencer (busy flag)
//            and 1-cycle registered read data.
// Options  : REGFILE_BYPASS_EN - when defined, a same-edge write to a read
//            port's address is forwarded to that port (write-first).
//            When undefined, reads are read-before-write.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_multiport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2   // legal range 1..4
) (
  input wire logic           clk,
  input wire logic           rst,
  regfile_multiport_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_lastIdx  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_firstIdx = ADDR_W'(1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_stateNext;
  logic [ADDR_W-1:0]        r_clrIdx;
  logic [ADDR_W-1:0]        w_clrIdxNext;
  logic                     r_busy;
  logic                     w_busyNext;

  logic                     w_memWe;
  logic [ADDR_W-1:0]        w_memAddr;
  logic [DATA_W-1:0]        w_memData;
  logic [DATA_W-1:0]        r_mem [DEPTH];

  logic [NUM_RD*DATA_W-1:0] w_rdData;
  logic [NUM_RD*DATA_W-1:0] r_regData;

  // Sequencer state register; reset restarts the clear from index 1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= CLEAR;
      r_clrIdx <= c_firstIdx;
      r_busy   <= 1'b1;
    end else begin
      r_state  <= w_stateNext;
      r_clrIdx <= w_clrIdxNext;
      r_busy   <= w_busyNext;
    end
  end

  // Next state and the single array write port (clear walker or WB write)
  always_comb begin
    w_stateNext  = r_state;
    w_clrIdxNext = r_clrIdx;
    w_busyNext   = r_busy;
    w_memWe      = 1'b0;
    w_memAddr    = r_clrIdx;
    w_memData    = '0;
    if (r_state == CLEAR) begin
      // User writes are ignored; zero the current index and advance.
      // The index is held at the last entry so it never wraps.
      w_memWe = 1'b1;
      if (r_clrIdx == c_lastIdx) begin
        w_stateNext = IDLE;
        w_busyNext  = 1'b0;
      end else begin
        w_clrIdxNext = r_clrIdx + c_firstIdx;
      end
    end else begin
      w_memWe   = bus.WB && (bus.writeReg != '0);
      w_memAddr = bus.writeReg;
      w_memData = bus.writeData;
    end
  end

  // Array write; the reset edge itself leaves the contents untouched
  always_ff @(posedge clk) begin
    if (!rst && w_memWe) begin
      r_mem[w_memAddr] <= w_memData;
    end
  end

  // Per-port read mux: address 0 reads zero, optional write-first forwarding
  always_comb begin
    w_rdData = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (bus.readReg[i*ADDR_W +: ADDR_W] != '0) begin
        w_rdData[i*DATA_W +: DATA_W] = r_mem[bus.readReg[i*ADDR_W +: ADDR_W]];
      end
`ifdef REGFILE_BYPASS_EN
      // w_memWe in IDLE already excludes address 0 and WB=0
      if ((r_state == IDLE) && w_memWe &&
          (bus.writeReg == bus.readReg[i*ADDR_W +: ADDR_W])) begin
        w_rdData[i*DATA_W +: DATA_W] = bus.writeData;
      end
`endif
    end
  end

  // Registered read data; forced to zero on reset and throughout the clear
  always_ff @(posedge clk) begin
    if (rst || (r_state == CLEAR)) begin
      r_regData <= '0;
    end else begin
      r_regData <= w_rdData;
    end
  end

  assign bus.RegData = r_regData;
  assign bus.busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_multiport
// Purpose  : Self-checking bench for regfile_multiport. Drives a default
//            instance (32b x 32, 2 read ports) and a small one (16b x 8,
//            4 read ports) side by side against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_multiport;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;

  // Stimulus, index 0 = default instance, 1 = small instance
  logic        inWB [2];
  logic [4:0]  inWA [2];
  logic [31:0] inWD [2];
  logic [4:0]  inRA [2][4];

  regfile_multiport_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifA ();
  regfile_multiport_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) ifB ();

  assign ifA.WB        = inWB[0];
  assign ifA.writeReg  = inWA[0];
  assign ifA.writeData = inWD[0];
  assign ifA.readReg   = {inRA[0][1], inRA[0][0]};
  assign ifB.WB        = inWB[1];
  assign ifB.writeReg  = inWA[1][2:0];
  assign ifB.writeData = inWD[1][15:0];
  assign ifB.readReg   = {inRA[1][3][2:0], inRA[1][2][2:0], inRA[1][1][2:0], inRA[1][0][2:0]};

  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dutA (
    .clk(clk), .rst(rst), .bus(ifA)
  );
  regfile_multiport #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) dutB (
    .clk(clk), .rst(rst), .bus(ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: architectural register contents, expected outputs,
  // and number of clear edges still to go
  int          depthM [2] = '{32, 8};
  int          nrdM   [2] = '{2, 4};
  logic [31:0] maskM  [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};
  logic [31:0] mMem   [2][32];
  logic [31:0] mData  [2][4];
  int          mClearLeft [2];

  int nCompared;
  int nMismatched;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the currently applied inputs
  task automatic modelEdge(input int b);
    int ra;
    int wa;
    wa = int'(inWA[b]) % depthM[b];
    if (rst) begin
      mClearLeft[b] = depthM[b] - 1;
      for (int i = 0; i < 4; i++) mData[b][i] = '0;
    end else if (mClearLeft[b] > 0) begin
      mClearLeft[b]--;
      for (int i = 0; i < 4; i++) mData[b][i] = '0;
      if (mClearLeft[b] == 0) begin
        for (int j = 0; j < 32; j++) mMem[b][j] = '0;
      end
    end else begin
      for (int i = 0; i < nrdM[b]; i++) begin
        ra = int'(inRA[b][i]) % depthM[b];
        if (ra == 0)
          mData[b][i] = '0;
        else if (BYP && inWB[b] && wa != 0 && wa == ra)
          mData[b][i] = inWD[b] & maskM[b];
        else
          mData[b][i] = mMem[b][ra];
      end
      if (inWB[b] && wa != 0) mMem[b][wa] = inWD[b] & maskM[b];
    end
  endtask

  task automatic checkAll();
    check("busyA", {31'b0, ifA.busy}, {31'b0, mClearLeft[0] > 0});
    for (int i = 0; i < 2; i++)
      check($sformatf("dataA%0d", i), ifA.RegData[i*32 +: 32], mData[0][i]);
    check("busyB", {31'b0, ifB.busy}, {31'b0, mClearLeft[1] > 0});
    for (int i = 0; i < 4; i++)
      check($sformatf("dataB%0d", i), {16'b0, ifB.RegData[i*16 +: 16]}, mData[1][i]);
  endtask

  // One clock: model on the rising edge, compare on the falling edge
  task automatic step();
    @(posedge clk);
    modelEdge(0);
    modelEdge(1);
    @(negedge clk);
    checkAll();
  endtask

  // Count edges until busy drops on both instances (bounded)
  task automatic countBusy(input string tag);
    int edgesA;
    int edgesB;
    edgesA = -1;
    edgesB = -1;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (edgesA < 0 && !ifA.busy) edgesA = n;
      if (edgesB < 0 && !ifB.busy) edgesB = n;
      if (edgesA >= 0 && edgesB >= 0) break;
    end
    check({tag, "_busyEdgesA"}, 32'(edgesA), 32'd31);
    check({tag, "_busyEdgesB"}, 32'(edgesB), 32'd7);
  endtask

  task automatic idleInputs();
    for (int b = 0; b < 2; b++) begin
      inWB[b] = 1'b0;
      inWA[b] = '0;
      inWD[b] = '0;
      for (int i = 0; i < 4; i++) inRA[b][i] = '0;
    end
  endtask

  typedef struct {
    logic        wb;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t tbl [9];

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    for (int b = 0; b < 2; b++) begin
      mClearLeft[b] = 0;
      for (int i = 0; i < 4; i++) mData[b][i] = '0;
      for (int j = 0; j < 32; j++) mMem[b][j] = '0;
    end

    // Directed vectors on the default instance, starting from a cleared file
    tbl[0] = '{1'b1, 5'd20, 32'd50,         5'd20, 5'd0,  BYP ? 32'd50 : 32'd0, 32'd0};
    tbl[1] = '{1'b0, 5'd0,  32'd0,          5'd20, 5'd0,  32'd50,               32'd0};
    tbl[2] = '{1'b1, 5'd0,  32'hDEADBEEF,   5'd0,  5'd0,  32'd0,                32'd0};
    tbl[3] = '{1'b0, 5'd0,  32'd0,          5'd0,  5'd0,  32'd0,                32'd0};
    tbl[4] = '{1'b1, 5'd11, 32'd4,          5'd9,  5'd11, 32'd0,                BYP ? 32'd4 : 32'd0};
    tbl[5] = '{1'b1, 5'd11, 32'd7,          5'd11, 5'd20, BYP ? 32'd7 : 32'd4,  32'd50};
    tbl[6] = '{1'b0, 5'd0,  32'd0,          5'd11, 5'd11, 32'd7,                32'd7};
    tbl[7] = '{1'b1, 5'd9,  32'd5,          5'd31, 5'd9,  32'd0,                BYP ? 32'd5 : 32'd0};
    tbl[8] = '{1'b0, 5'd0,  32'd0,          5'd9,  5'd20, 32'd5,                32'd50};

    // Power-on reset and first clear
    idleInputs();
    rst = 1'b1;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    countBusy("init");

    for (int k = 0; k < 9; k++) begin
      inWB[0]    = tbl[k].wb;
      inWA[0]    = tbl[k].wa;
      inWD[0]    = tbl[k].wd;
      inRA[0][0] = tbl[k].ra0;
      inRA[0][1] = tbl[k].ra1;
      step();
      check($sformatf("tbl%0d_port0", k), ifA.RegData[31:0],  tbl[k].e0);
      check($sformatf("tbl%0d_port1", k), ifA.RegData[63:32], tbl[k].e1);
    end

    // Reset clear: reg 9 holds 5, reads of it stay 0 during the clear
    idleInputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    inRA[0][0] = 5'd9;
    inRA[0][1] = 5'd20;
    countBusy("clr");
    step();
    check("clr_reg9",  ifA.RegData[31:0],  32'd0);
    check("clr_reg20", ifA.RegData[63:32], 32'd0);

    // Reset mid-clear with WB pulses during the clear
    idleInputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      inWB[0] = (n <= 3);
      inWA[0] = 5'd12;
      inWD[0] = 32'h1234_5678;
      inWB[1] = (n <= 3);
      inWA[1] = 5'd6;
      inWD[1] = 32'h0000_ABCD;
      step();
    end
    idleInputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    countBusy("midclr");
    inRA[0][0] = 5'd12;
    inRA[1][0] = 5'd6;
    step();
    check("midclr_regA12", ifA.RegData[31:0], 32'd0);
    check("midclr_regB6",  {16'b0, ifB.RegData[15:0]}, 32'd0);

    // Small instance: four independent ports
    idleInputs();
    for (int k = 1; k <= 4; k++) begin
      inWB[1] = 1'b1;
      inWA[1] = 5'(k);
      inWD[1] = 32'(k * 32'h1111);
      step();
    end
    idleInputs();
    for (int i = 0; i < 4; i++) inRA[1][i] = 5'(i + 1);
    step();
    for (int i = 0; i < 4; i++)
      check($sformatf("param_port%0d", i), {16'b0, ifB.RegData[i*16 +: 16]}, 32'((i + 1) * 32'h1111));
    for (int i = 0; i < 4; i++) inRA[1][i] = 5'(4 - i);
    step();
    for (int i = 0; i < 4; i++)
      check($sformatf("paramRev_port%0d", i), {16'b0, ifB.RegData[i*16 +: 16]}, 32'((4 - i) * 32'h1111));

    // Randomised traffic with occasional resets
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int b = 0; b < 2; b++) begin
        inWB[b] = 1'($urandom_range(0, 1));
        if (b == 0 && $urandom_range(0, 1) == 1)
          inWA[b] = 5'($urandom_range(0, 7));
        else
          inWA[b] = 5'($urandom_range(0, depthM[b] - 1));
        inWD[b] = $urandom;
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(0, 2) == 0)
            inRA[b][i] = inWA[b];
          else
            inRA[b][i] = 5'($urandom_range(0, depthM[b] - 1));
        end
      end
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  // Run-time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
